// File: rtl/ex_stage.sv
// ex_stage: execute stage that sits directly after the ID/EX pipeline register.
//   - Forwards rs1/rs2 from its own EX/MEM register (priority) or from MEM/WB.
//   - Single-cycle ALU with a result latency of one edge.
//   - Optional iterative MUL/DIVU/REMU unit. It is built only when the macro
//     EX_MULDIV_EN is defined. While the unit is busy it stalls the front end.
//   - Writes every result into the EX/MEM output register owned by this block.
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   Valid, ALUOp        instruction present, operation code
//   PC, rs1val, rs2val, auipcOrlui   ID/EX operands and immediate
//   ALUSourceA/B        operand select (A: rs1/PC, B: rs2/imm/4/0)
//   IDEXrs1/rs2/rd, IDEXregWrite     ID/EX register indices, write enable
//   MEMWBrd, MEMWBregWrite, MEMWBResult   MEM/WB forwarding source
//   Flush               kill the instruction in EX, abort any muldiv
//   Stall               freeze PC, IF/ID and ID/EX
//   EXMEM*              registered result, store data, rd, write enable, valid
module ex_stage #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Valid,
    input  logic [4:0]      ALUOp,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] rs1val,
    input  logic [XLEN-1:0] rs2val,
    input  logic [XLEN-1:0] auipcOrlui,
    input  logic            ALUSourceA,
    input  logic [1:0]      ALUSourceB,
    input  logic [4:0]      IDEXrs1,
    input  logic [4:0]      IDEXrs2,
    input  logic [4:0]      IDEXrd,
    input  logic            IDEXregWrite,
    input  logic [4:0]      MEMWBrd,
    input  logic            MEMWBregWrite,
    input  logic [XLEN-1:0] MEMWBResult,
    input  logic            Flush,
    output logic            Stall,
    output logic [XLEN-1:0] EXMEMResult,
    output logic [XLEN-1:0] EXMEMrs2val,
    output logic [4:0]      EXMEMrd,
    output logic            EXMEMregWrite,
    output logic            EXMEMvalid
);

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res;
    logic [4:0]      shamt;
    logic            md_done;
    logic [XLEN-1:0] md_res;
    logic [4:0]      md_rd;
    logic            md_rw;

    // Register 0 never forwards. EX/MEM is younger than MEM/WB, so it wins.
    always_comb begin
        fwd_rs1 = rs1val;
        if (EXMEMregWrite && EXMEMrd != 5'd0 && EXMEMrd == IDEXrs1)
            fwd_rs1 = EXMEMResult;
        else if (MEMWBregWrite && MEMWBrd != 5'd0 && MEMWBrd == IDEXrs1)
            fwd_rs1 = MEMWBResult;

        fwd_rs2 = rs2val;
        if (EXMEMregWrite && EXMEMrd != 5'd0 && EXMEMrd == IDEXrs2)
            fwd_rs2 = EXMEMResult;
        else if (MEMWBregWrite && MEMWBrd != 5'd0 && MEMWBrd == IDEXrs2)
            fwd_rs2 = MEMWBResult;
    end

    always_comb begin
        op_a = ALUSourceA ? PC : fwd_rs1;
        case (ALUSourceB)
            2'd0:    op_b = fwd_rs2;
            2'd1:    op_b = auipcOrlui;
            2'd2:    op_b = XLEN'(4);
            default: op_b = '0;
        endcase
    end

    assign shamt = op_b[4:0];

    // Codes 16-18 fall into the default arm here; the muldiv unit produces them.
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            5'd0:    alu_res = op_a + op_b;
            5'd1:    alu_res = op_a - op_b;
            5'd2:    alu_res = op_a << shamt;
            5'd3:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            5'd4:    alu_res = XLEN'(op_a < op_b);
            5'd5:    alu_res = op_a ^ op_b;
            5'd6:    alu_res = op_a >> shamt;
            5'd7:    alu_res = XLEN'($signed(op_a) >>> shamt);
            5'd8:    alu_res = op_a | op_b;
            5'd9:    alu_res = op_a & op_b;
            5'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    // state   | meaning
    // MD_IDLE | no muldiv in flight; issue when a muldiv op is valid
    // MD_BUSY | one shift-add / restoring-divide step per cycle
    // MD_DONE | result ready; EX/MEM loads it on this edge
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    md_state_t       state, state_nx;
    logic [CNT_W-1:0] md_cnt;
    logic [XLEN-1:0] md_a, md_b, md_acc;
    logic [1:0]      md_op;
    logic            is_md_op, md_issue;
    logic [XLEN:0]   rem_sh;

    assign is_md_op = (ALUOp == 5'd16) || (ALUOp == 5'd17) || (ALUOp == 5'd18);
    assign md_issue = !RST && (state == MD_IDLE) && Valid && is_md_op && !Flush;
    assign Stall    = md_issue || (!RST && (state == MD_BUSY) && !Flush);
    assign md_done  = (state == MD_DONE);
    // md_op: 0 MUL, 1 DIVU, 2 REMU. Quotient builds up in md_b, remainder in md_acc.
    assign md_res   = (md_op == 2'd1) ? md_b : md_acc;
    assign rem_sh   = {md_acc, md_b[XLEN-1]};

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (md_issue) state_nx = MD_BUSY;
            MD_BUSY: if (md_cnt == CNT_W'(1)) state_nx = MD_DONE;
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
        if (Flush) state_nx = MD_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= MD_IDLE;
        else     state <= state_nx;
    end

    // Operands are latched at issue, so later MEM/WB activity cannot disturb them.
    // A zero divisor needs no special case: every compare succeeds, giving an
    // all-ones quotient and leaving the dividend as the remainder.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            md_a   <= '0;
            md_b   <= '0;
            md_acc <= '0;
            md_op  <= '0;
            md_cnt <= '0;
            md_rd  <= '0;
            md_rw  <= 1'b0;
        end else if (md_issue) begin
            md_op  <= ALUOp[1:0];
            md_rd  <= IDEXrd;
            md_rw  <= IDEXregWrite;
            md_cnt <= CNT_W'(MD_CYCLES);
            md_acc <= '0;
            if (ALUOp == 5'd16) begin
                md_a <= op_a;
                md_b <= op_b;
            end else begin
                md_a <= op_b;
                md_b <= op_a;
            end
        end else if (state == MD_BUSY) begin
            md_cnt <= md_cnt - CNT_W'(1);
            if (md_op == 2'd0) begin
                if (md_b[0]) md_acc <= md_acc + md_a;
                md_a <= md_a << 1;
                md_b <= md_b >> 1;
            end else if (rem_sh >= {1'b0, md_a}) begin
                md_acc <= rem_sh[XLEN-1:0] - md_a;
                md_b   <= {md_b[XLEN-2:0], 1'b1};
            end else begin
                md_acc <= rem_sh[XLEN-1:0];
                md_b   <= {md_b[XLEN-2:0], 1'b0};
            end
        end
    end
`else
    logic [31:0] unused_md_cycles;
    assign unused_md_cycles = MD_CYCLES;
    assign Stall   = 1'b0;
    assign md_done = 1'b0;
    assign md_res  = '0;
    assign md_rd   = '0;
    assign md_rw   = 1'b0;
`endif

    // A bubble clears valid/regWrite/rd. Result and store data keep their old
    // values, which avoids toggling the wide buses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EXMEMResult   <= '0;
            EXMEMrs2val   <= '0;
            EXMEMrd       <= '0;
            EXMEMregWrite <= 1'b0;
            EXMEMvalid    <= 1'b0;
        end else if (Flush) begin
            EXMEMrd       <= '0;
            EXMEMregWrite <= 1'b0;
            EXMEMvalid    <= 1'b0;
        end else if (md_done) begin
            EXMEMResult   <= md_res;
            EXMEMrs2val   <= fwd_rs2;
            EXMEMrd       <= md_rd;
            EXMEMregWrite <= md_rw;
            EXMEMvalid    <= 1'b1;
        end else if (Valid && !Stall) begin
            EXMEMResult   <= alu_res;
            EXMEMrs2val   <= fwd_rs2;
            EXMEMrd       <= IDEXrd;
            EXMEMregWrite <= IDEXregWrite;
            EXMEMvalid    <= 1'b1;
        end else begin
            EXMEMrd       <= '0;
            EXMEMregWrite <= 1'b0;
            EXMEMvalid    <= 1'b0;
        end
    end

endmodule
